// File: rtl/shift_frame_sequencer.sv
// Frame sequencer for a serial-in/serial-out shift register: shifts a parallel
// word in one bit per clock while capturing the word that falls out.
module shift_frame_sequencer #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic             abort,
  output logic             shift_en,
  output logic             shift_in,
  input  logic             shift_out,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             busy,
  output logic [7:0]       frame_cnt
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [WIDTH-1:0] rx_data_d;
  logic [7:0]       frame_cnt_d;
  logic             tx_ready_d, shift_en_d, shift_in_d, rx_valid_d, busy_d;

  // Maps shift cycle k to the word bit it carries.
  function automatic logic [CNT_W-1:0] bit_pos(input logic [CNT_W-1:0] k);
    return MSB_FIRST ? (LAST - k) : k;
  endfunction

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      hold_q    <= '0;
      rx_sr_q   <= '0;
      rx_data   <= '0;
      frame_cnt <= 8'd0;
      tx_ready  <= 1'b1;
      shift_en  <= 1'b0;
      shift_in  <= 1'b0;
      rx_valid  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      hold_q    <= hold_d;
      rx_sr_q   <= rx_sr_d;
      rx_data   <= rx_data_d;
      frame_cnt <= frame_cnt_d;
      tx_ready  <= tx_ready_d;
      shift_en  <= shift_en_d;
      shift_in  <= shift_in_d;
      rx_valid  <= rx_valid_d;
      busy      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    hold_d      = hold_q;
    rx_sr_d     = rx_sr_q;
    rx_data_d   = rx_data;
    frame_cnt_d = frame_cnt;

    unique case (state_q)
      IDLE: begin
        if (tx_valid) begin
          hold_d    = tx_data;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // The register shifts on this edge, so shift_out is the bit leaving it.
        rx_sr_d[bit_pos(bit_cnt_q)] = shift_out;
        if (abort) begin
          state_d = IDLE;
        end else if (bit_cnt_q == LAST) begin
          rx_data_d   = rx_sr_d;
          frame_cnt_d = frame_cnt + 8'd1;
          state_d     = DONE;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (rx_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered copies of what the next state presents.
    tx_ready_d = (state_d == IDLE);
    shift_en_d = (state_d == SHIFT);
    rx_valid_d = (state_d == DONE);
    busy_d     = (state_d != IDLE);
    shift_in_d = shift_en_d ? hold_d[bit_pos(bit_cnt_d)] : 1'b0;
  end

endmodule

// File: tb/tb_shift_frame_sequencer.sv
// Self-checking bench: directed frame table, abort/reset corners, and a
// randomized run against a word-level exchange model of the shift register.
module tb_shift_frame_sequencer;
  localparam int unsigned W = 4;

  logic         CLK = 1'b0;
  logic         Reset = 1'b1;
  logic [W-1:0] tx_data = '0;
  logic         tx_valid = 1'b0;
  logic         tx_ready;
  logic         abort = 1'b0;
  logic         shift_en;
  logic         shift_in;
  logic         shift_out;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         rx_ready = 1'b0;
  logic         busy;
  logic [7:0]   frame_cnt;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  shift_frame_sequencer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut (
    .CLK(CLK), .Reset(Reset),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .abort(abort),
    .shift_en(shift_en), .shift_in(shift_in), .shift_out(shift_out),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  // External register: Shift_in enters at the top, shift_out is the oldest bit.
  logic [W-1:0] reg_q;
  always @(posedge CLK) begin
    if (Reset) reg_q <= '0;
    else if (shift_en) reg_q <= {shift_in, reg_q[W-1:1]};
  end
  assign shift_out = reg_q[0];

  typedef struct {
    logic [W-1:0] data;
    int           delay;
    bit           hold_valid;
    logic [W-1:0] exp_rx;
    logic [7:0]   exp_cnt;
  } vec_t;

  vec_t vecs[4];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_frame(input logic [W-1:0] d, input int delay, input bit hold_valid,
                           input logic [W-1:0] exp_rx, input logic [7:0] exp_cnt);
    int n;
    int cyc;
    int nsh;
    logic [W-1:0] sin;
    n = 0;
    while (!tx_ready && n < 20) begin
      tick();
      n++;
    end
    check("tx_ready_idle", int'(tx_ready), 1);
    tx_data  = d;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    nsh = 0;
    cyc = 0;
    sin = '0;
    while (!rx_valid && cyc < 12) begin
      if (shift_en) begin
        if (nsh < int'(W)) sin[nsh] = shift_in;
        nsh++;
      end
      tick();
      cyc++;
    end
    check("latency", cyc, int'(W));
    check("shift_cnt", nsh, int'(W));
    check("shift_in_seq", int'(sin), int'(d));
    check("rx_data", int'(rx_data), int'(exp_rx));
    check("frame_cnt", int'(frame_cnt), int'(exp_cnt));
    check("reg_contents", int'(reg_q), int'(d));
    check("busy_done", int'(busy), 1);
    for (int i = 0; i < delay; i++) begin
      tx_valid = hold_valid;
      abort    = (i == 1);
      tick();
      check("hold_valid", int'(rx_valid), 1);
      check("hold_data", int'(rx_data), int'(exp_rx));
      check("hold_tx_ready", int'(tx_ready), 0);
      check("hold_no_shift", int'(shift_en), 0);
      check("hold_shift_in", int'(shift_in), 0);
    end
    abort    = 1'b0;
    tx_valid = 1'b0;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    check("rx_valid_drop", int'(rx_valid), 0);
    check("tx_ready_back", int'(tx_ready), 1);
    check("busy_idle", int'(busy), 0);
  endtask

  initial begin
    logic [W-1:0] model_word;
    logic [W-1:0] d;
    int delay;

    vecs[0] = '{4'b1011, 0, 1'b0, 4'b0000, 8'd1};
    vecs[1] = '{4'b0110, 0, 1'b0, 4'b1011, 8'd2};
    vecs[2] = '{4'b1100, 5, 1'b1, 4'b0110, 8'd3};
    vecs[3] = '{4'b0001, 2, 1'b0, 4'b1100, 8'd4};

    // Reset held two cycles.
    tick();
    tick();
    check("rst_tx_ready", int'(tx_ready), 1);
    check("rst_shift_en", int'(shift_en), 0);
    check("rst_shift_in", int'(shift_in), 0);
    check("rst_rx_data", int'(rx_data), 0);
    check("rst_rx_valid", int'(rx_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_cnt", int'(frame_cnt), 0);
    Reset = 1'b0;
    tick();

    foreach (vecs[i])
      run_frame(vecs[i].data, vecs[i].delay, vecs[i].hold_valid, vecs[i].exp_rx, vecs[i].exp_cnt);

    // Abort in shift cycle 2: three ones reach the register, nothing is returned.
    tx_data  = 4'b1111;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tick();
    tick();
    check("abort_in_shift", int'(shift_en), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_shift_en", int'(shift_en), 0);
    check("abort_tx_ready", int'(tx_ready), 1);
    check("abort_busy", int'(busy), 0);
    check("abort_rx_valid", int'(rx_valid), 0);
    check("abort_frame_cnt", int'(frame_cnt), 4);
    check("abort_rx_data", int'(rx_data), int'(4'b1100));
    check("abort_reg", int'(reg_q), int'(4'b1110));
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_no_rx_valid", int'(rx_valid), 0);
    end
    run_frame(4'b0101, 0, 1'b0, 4'b1110, 8'd5);

    // Reset in the middle of a shift.
    tx_data  = 4'b1010;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("mid_rst_shift_en", int'(shift_en), 0);
    check("mid_rst_tx_ready", int'(tx_ready), 1);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_rx_valid", int'(rx_valid), 0);
    check("mid_rst_rx_data", int'(rx_data), 0);
    check("mid_rst_frame_cnt", int'(frame_cnt), 0);
    tick();

    // 256 random frames: each frame returns the previous word; counter wraps.
    model_word = '0;
    for (int f = 0; f < 256; f++) begin
      d     = W'($urandom);
      delay = int'($urandom_range(0, 3));
      run_frame(d, delay, 1'($urandom_range(0, 1)), model_word, 8'(f + 1));
      model_word = d;
      repeat ($urandom_range(0, 2)) tick();
    end
    check("frame_cnt_wrap", int'(frame_cnt), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
